// File: rtl/cpu16_decode_stage.sv
// cpu16_decode_stage: registered instruction decode between fetch and execute, valid/ready on both
// sides. Define DECODE_SKID_EN to add one skid entry behind the output register.
module cpu16_decode_stage #(
  parameter int unsigned RA = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*RA+7:0] ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      icnt,
  output logic [RA-1:0]   dest,
  output logic [RA-1:0]   src,
  output logic [DW-1:0]   imm,
  output logic            ill,
  output logic            halted,
  output logic [CW-1:0]   ill_cnt,
  input  logic            clr_ill
);
  localparam int unsigned IW = 2 * RA + 8;

  typedef struct packed {
    logic [7:0]    icnt;
    logic [RA-1:0] dest;
    logic [RA-1:0] src;
    logic [DW-1:0] imm;
    logic          ill;
  } dec_t;

  dec_t          dec_in;
  dec_t          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] ill_cnt_q, ill_cnt_d;
  logic          accept;
  logic [3:0]    op, func;
  logic [RA+3:0] fimm;

  always_comb begin
    op          = ir[IW-1 -: 4];
    func        = ir[RA+3:RA];
    fimm        = ir[RA+3:0];
    dec_in      = '0;
    dec_in.dest = ir[IW-5 -: RA];
    dec_in.src  = ir[RA-1:0];
    case (op)
      4'h0: begin
        case (func)
          4'b1010: dec_in.icnt = 8'h01;
          4'b0010: dec_in.icnt = 8'h02;
          4'b1100: dec_in.icnt = 8'h04;
          4'b1110: dec_in.icnt = 8'h08;
          4'b0110: dec_in.icnt = 8'h10;
          default: dec_in.icnt = 8'h00;
        endcase
      end
      4'h1: begin
        dec_in.icnt = 8'h20;
        dec_in.imm  = DW'(fimm);
      end
      4'h2: begin
        dec_in.icnt = 8'h40;
        dec_in.imm  = DW'($signed(fimm));
      end
      4'hf:    dec_in.icnt = 8'h80;
      default: dec_in.icnt = 8'h00;
    endcase
    dec_in.ill = (dec_in.icnt == 8'h00);
  end

  assign halted_d = halted_q | (accept & dec_in.icnt[7]);

  // A clear coinciding with an illegal accept counts that accept.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (clr_ill) begin
      ill_cnt_d = (accept && dec_in.ill) ? CW'(1) : '0;
    end else if (accept && dec_in.ill && ill_cnt_q != '1) begin
      ill_cnt_d = ill_cnt_q + CW'(1);
    end
  end

`ifdef DECODE_SKID_EN
  dec_t skid_q, skid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign accept   = in_valid & in_ready_q;

  // in_ready_q already excludes a full skid entry, so accept and skid_valid_q never coincide.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d && !halted_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !halted_q && (!out_valid_q || out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = dec_in;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      ill_cnt_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign icnt      = out_q.icnt;
  assign dest      = out_q.dest;
  assign src       = out_q.src;
  assign imm       = out_q.imm;
  assign ill       = out_q.ill;
  assign halted    = halted_q;
  assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_cpu16_decode_stage.sv
// Bench for cpu16_decode_stage: random and directed stimulus against a queue-based reference model.
module tb_cpu16_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  icnt;
  logic [3:0]  dest;
  logic [3:0]  src;
  logic [15:0] imm;
  logic        ill;
  logic        halted;
  logic [7:0]  ill_cnt;
  logic        clr_ill;

  int nchk  = 0;
  int npass = 0;

  typedef struct packed {
    logic [7:0]  icnt;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [15:0] imm;
    logic        ill;
  } exp_t;

  exp_t       q[$];
  logic [7:0] emitted[$];
  logic       halted_m;
  logic [7:0] cnt_m;
  int         codes[5] = '{10, 2, 12, 14, 6};

  cpu16_decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir        (ir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .icnt      (icnt),
    .dest      (dest),
    .src       (src),
    .imm       (imm),
    .ill       (ill),
    .halted    (halted),
    .ill_cnt   (ill_cnt),
    .clr_ill   (clr_ill)
  );

  always #5 clk = ~clk;

  function automatic bit legal_func(input logic [3:0] fn);
    for (int i = 0; i < 5; i++) if (int'(fn) == codes[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t ref_decode(input logic [15:0] w);
    exp_t e;
    int   op;
    op     = int'(w[15:12]);
    e.dest = w[11:8];
    e.src  = w[3:0];
    e.imm  = 16'h0000;
    e.icnt = 8'h00;
    if (op == 0) begin
      for (int i = 0; i < 5; i++) if (int'(w[7:4]) == codes[i]) e.icnt = 8'(1 << i);
    end else if (op == 1) begin
      e.icnt = 8'(1 << 5);
      e.imm  = {8'h00, w[7:0]};
    end else if (op == 2) begin
      e.icnt = 8'(1 << 6);
      e.imm  = w[7] ? 16'(int'(w[7:0]) - 256) : {8'h00, w[7:0]};
    end else if (op == 15) begin
      e.icnt = 8'(1 << 7);
    end
    e.ill = (e.icnt == 8'h00);
    return e;
  endfunction

  function automatic logic [15:0] rand_illegal();
    logic [15:0] w;
    logic [3:0]  fn;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 0) begin
      w[15:12] = 4'h0;
      do fn = 4'($urandom); while (legal_func(fn));
      w[7:4] = fn;
    end else begin
      w[15:12] = 4'($urandom_range(3, 14));
    end
    return w;
  endfunction

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [15:0] w;
    int          k;
    w = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k < 5) begin
      w[15:12] = 4'h0;
      w[7:4]   = 4'(codes[k]);
    end else if (k == 5) w[15:12] = 4'h1;
    else if (k == 6) w[15:12] = 4'h2;
    else if (k == 9 && allow_halt) w[15:12] = 4'hf;
    else w = rand_illegal();
    return w;
  endfunction

  // One clock: check outputs at the negedge, then advance the model past the posedge.
  task automatic step(output logic acc, output logic xo);
    exp_t        e;
    logic        exp_rdy;
    logic [15:0] w;
    logic        clr;
    @(negedge clk);
    nchk++;
    if (out_valid !== (q.size() != 0))
      $display("FAIL out_valid: got %b want %b", out_valid, q.size() != 0);
    else npass++;
    if (q.size() != 0) begin
      e = q[0];
      nchk++;
      if ({icnt, dest, src, imm, ill} !== {e.icnt, e.dest, e.src, e.imm, e.ill})
        $display("FAIL decode: got icnt=%h dest=%h src=%h imm=%h ill=%b want %h %h %h %h %b",
                 icnt, dest, src, imm, ill, e.icnt, e.dest, e.src, e.imm, e.ill);
      else npass++;
    end
    nchk++;
    if (halted !== halted_m) $display("FAIL halted: got %b want %b", halted, halted_m);
    else npass++;
    nchk++;
    if (ill_cnt !== cnt_m) $display("FAIL ill_cnt: got %h want %h", ill_cnt, cnt_m);
    else npass++;
`ifdef DECODE_SKID_EN
    exp_rdy = !halted_m && (q.size() < 2);
`else
    exp_rdy = !halted_m && (q.size() == 0 || out_ready);
`endif
    nchk++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    else npass++;
    acc = in_valid && in_ready;
    xo  = out_valid && out_ready;
    w   = ir;
    clr = clr_ill;
    @(posedge clk);
    #1;
    if (xo && q.size() != 0) begin
      e = q.pop_front();
      emitted.push_back(e.icnt);
    end
    e = ref_decode(w);
    if (clr) cnt_m = (acc && e.ill) ? 8'd1 : 8'd0;
    else if (acc && e.ill && cnt_m != 8'hff) cnt_m = cnt_m + 8'd1;
    if (acc) begin
      q.push_back(e);
      if (e.icnt == 8'h80) halted_m = 1'b1;
    end
`ifdef DECODE_SKID_EN
    if (q.size() > 2) begin
      nchk++;
      $display("FAIL capacity: got %0d want <=2", q.size());
    end
`else
    if (q.size() > 1) begin
      nchk++;
      $display("FAIL capacity: got %0d want <=1", q.size());
    end
`endif
  endtask

  task automatic model_clear();
    q.delete();
    halted_m = 1'b0;
    cnt_m    = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_ill  = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic a, x;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_ill   = 1'b0;
    repeat (3) step(a, x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ill = 1'b0; ir = 16'h0000;
    model_clear();
    #2;
    nchk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else npass++;
    nchk++; if (icnt !== 8'h00) $display("FAIL rst_icnt: got %h want 00", icnt); else npass++;
    nchk++; if ({dest, src, imm} !== 24'h0) $display("FAIL rst_fields: got %h want 0",
                                                      {dest, src, imm});
    else npass++;
    nchk++; if (ill !== 1'b0) $display("FAIL rst_ill: got %b want 0", ill); else npass++;
    nchk++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else npass++;
    nchk++; if (ill_cnt !== 8'h00) $display("FAIL rst_ill_cnt: got %h want 00", ill_cnt);
    else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nchk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else npass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] vir[4]  = '{16'h03a5, 16'h21fe, 16'h12fe, 16'h0050};
    logic [36:0] vexp[4] = '{{8'h01, 4'h3, 4'h5, 16'h0000, 1'b0},
                             {8'h40, 4'h1, 4'he, 16'hfffe, 1'b0},
                             {8'h20, 4'h2, 4'he, 16'h00fe, 1'b0},
                             {8'h00, 4'h0, 4'h0, 16'h0000, 1'b1}};
    logic a, x;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ir = vir[i];
      in_valid = 1'b1;
      step(a, x);
      nchk++;
      if ({icnt, dest, src, imm, ill} !== vexp[i])
        $display("FAIL directed_%0d: got %h want %h", i, {icnt, dest, src, imm, ill}, vexp[i]);
      else npass++;
    end
    nchk++; if (ill_cnt !== 8'd1) $display("FAIL directed_ill_cnt: got %h want 01", ill_cnt);
    else npass++;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic a, x;
    int   nacc = 0;
    drain();
    emitted.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ir = rand_word(1'b0);
      step(a, x);
      if (a) nacc++;
    end
    in_valid = 1'b0;
    nchk++; if (nacc != 20) $display("FAIL b2b_accepts: got %0d want 20", nacc); else npass++;
    nchk++; if (emitted.size() != 19) $display("FAIL b2b_emitted: got %0d want 19",
                                                emitted.size());
    else npass++;
  endtask

  task automatic test_stall_stream();
    logic [15:0] words[4] = '{16'h01a2, 16'h0223, 16'h03c4, 16'h04e5};
    logic        pat[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  want;
    logic        a, x;
    int          idx = 0;
    drain();
    emitted.delete();
    for (int cyc = 0; cyc < 40 && emitted.size() < 4; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (idx < 4);
      ir        = words[idx % 4];
      step(a, x);
      if (a) idx++;
    end
    in_valid = 1'b0;
    nchk++; if (emitted.size() != 4) $display("FAIL stall_count: got %0d want 4", emitted.size());
    else npass++;
    for (int i = 0; i < emitted.size(); i++) begin
      want = 8'(1 << i);
      nchk++;
      if (emitted[i] !== want) $display("FAIL stall_order_%0d: got %h want %h", i, emitted[i], want);
      else npass++;
    end
  endtask

  task automatic test_ill_sat();
    logic a, x;
    drain();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ir = rand_illegal();
      step(a, x);
    end
    nchk++; if (ill_cnt !== 8'hff) $display("FAIL ill_sat: got %h want ff", ill_cnt); else npass++;
    ir = rand_illegal();
    clr_ill = 1'b1;
    step(a, x);
    nchk++; if (ill_cnt !== 8'h01) $display("FAIL clr_with_ill: got %h want 01", ill_cnt);
    else npass++;
    in_valid = 1'b0;
    step(a, x);
    nchk++; if (ill_cnt !== 8'h00) $display("FAIL clr_alone: got %h want 00", ill_cnt);
    else npass++;
    clr_ill = 1'b0;
  endtask

  task automatic test_random();
    logic a, x;
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ill   = ($urandom_range(0, 49) == 0);
      ir        = rand_word(1'b0);
      step(a, x);
    end
    clr_ill = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_halt();
    logic a, x;
    int   nafter = 0;
    int   nhalt  = 0;
    do_reset();
    emitted.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ir        = 16'hf000;
    step(a, x);
    nchk++; if (a !== 1'b1) $display("FAIL halt_accept: got %b want 1", a); else npass++;
    nchk++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %b want 1", halted); else npass++;
    nchk++; if (in_ready !== 1'b0) $display("FAIL halt_in_ready: got %b want 0", in_ready);
    else npass++;
    ir = 16'h03a5;
    repeat (8) begin
      step(a, x);
      if (a) nafter++;
    end
    foreach (emitted[i]) if (emitted[i] == 8'h80) nhalt++;
    nchk++; if (nafter != 0) $display("FAIL halt_no_accept: got %0d want 0", nafter); else npass++;
    nchk++; if (nhalt != 1) $display("FAIL halt_once: got %0d want 1", nhalt); else npass++;
    nchk++; if (out_valid !== 1'b0) $display("FAIL halt_drained: got %b want 0", out_valid);
    else npass++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic a, x;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ir        = 16'h0050;
    step(a, x);
    ir = 16'hf000;
    step(a, x);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step(a, x);
    nchk++; if (out_valid !== 1'b1 || halted !== 1'b1 || ill_cnt !== 8'd1)
      $display("FAIL mid_precond: got %b%b%h want 1101", out_valid, halted, ill_cnt);
    else npass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    nchk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid);
    else npass++;
    nchk++; if (icnt !== 8'h00) $display("FAIL mid_icnt: got %h want 00", icnt); else npass++;
    nchk++; if (ill_cnt !== 8'h00) $display("FAIL mid_ill_cnt: got %h want 00", ill_cnt);
    else npass++;
    nchk++; if (halted !== 1'b0) $display("FAIL mid_halted: got %b want 0", halted); else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nchk++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready);
    else npass++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      ir        = rand_word(1'b0);
      step(a, x);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_stream();
    test_ill_sat();
    test_random();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
